// File: rtl/game_state_ctrl.sv
// Game flow controller: start/play/dying/over sequencing, lives and pellet score,
// with per-ghost box collision evaluated once per frame tick.
module game_state_ctrl #(
    parameter int NUM_GHOSTS  = 4,
    parameter int HIT_RADIUS  = 8,
    parameter int LIVES       = 3,
    parameter int DYING_TICKS = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start,
    input  logic [9:0]              pac_x,
    input  logic [8:0]              pac_y,
    input  logic [10*NUM_GHOSTS-1:0] ghost_x,
    input  logic [9*NUM_GHOSTS-1:0]  ghost_y,
    input  logic [NUM_GHOSTS-1:0]   ghost_en,
    input  logic                    pellet,
    output logic [1:0]              state,
    output logic [3:0]              lives_left,
    output logic [15:0]             score,
    output logic [NUM_GHOSTS-1:0]   hit_mask,
    output logic                    respawn,
    output logic                    game_over
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // PLAY  | game running, pellets scored, collisions checked on tick
    // DYING | death animation, counts DYING_TICKS ticks
    // OVER  | no lives left; results held until start
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [10:0] RADIUS   = 11'(HIT_RADIUS);
    localparam logic [7:0]  DYING_TC = 8'(DYING_TICKS - 1);
    localparam logic [3:0]  LIVES_INIT = 4'(LIVES);

    state_t                  state_r;
    logic [7:0]              dying_cnt;
    logic [NUM_GHOSTS-1:0]   coll;

    // Magnitude carried in 11 bits so the subtraction can never wrap.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    always_comb begin
        coll = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            coll[i] = ghost_en[i]
                   && (abs_diff(pac_x, ghost_x[10*i +: 10]) < RADIUS)
                   && (abs_diff({1'b0, pac_y}, {1'b0, ghost_y[9*i +: 9]}) < RADIUS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            lives_left <= '0;
            score      <= '0;
            hit_mask   <= '0;
            respawn    <= 1'b0;
            game_over  <= 1'b0;
            dying_cnt  <= '0;
        end else begin
            respawn <= 1'b0;
            case (state_r)
                IDLE, OVER: begin
                    if (start) begin
                        state_r    <= PLAY;
                        lives_left <= LIVES_INIT;
                        score      <= '0;
                        hit_mask   <= '0;
                        game_over  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (pellet && score != 16'hFFFF)
                        score <= score + 16'd1;
                    if (tick && |coll) begin
                        state_r    <= DYING;
                        lives_left <= lives_left - 4'd1;
                        hit_mask   <= coll;
                        dying_cnt  <= '0;
                    end
                end
                DYING: begin
                    if (tick) begin
                        if (dying_cnt == DYING_TC) begin
                            dying_cnt <= '0;
                            if (lives_left == 4'd0) begin
                                state_r   <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                state_r <= PLAY;
                                respawn <= 1'b1;
                            end
                        end else begin
                            dying_cnt <= dying_cnt + 8'd1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed vector bench for game_state_ctrl (4 ghosts, radius 8, 3 lives, 2 dying ticks).
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pac_x = 10'd100;
    logic [8:0]  pac_y = 9'd100;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [3:0]  ghost_en = 4'b0000;
    logic        pellet = 1'b0;
    logic [1:0]  state;
    logic [3:0]  lives_left;
    logic [15:0] score;
    logic [3:0]  hit_mask;
    logic        respawn;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] FX = 10'd900;
    localparam logic [8:0] FY = 9'd400;

    game_state_ctrl #(
        .NUM_GHOSTS(4), .HIT_RADIUS(8), .LIVES(3), .DYING_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .ghost_en(ghost_en), .pellet(pellet), .state(state),
        .lives_left(lives_left), .score(score), .hit_mask(hit_mask),
        .respawn(respawn), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, tick, pellet;
        logic [39:0] gx;
        logic [35:0] gy;
        logic [3:0]  en;
        logic [1:0]  st;
        logic [3:0]  lv;
        logic [15:0] sc;
        logic [3:0]  hm;
        logic        rs, go;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [39:0] gx0(input logic [9:0] x);
        return {FX, FX, FX, x};
    endfunction
    function automatic logic [35:0] gy0(input logic [8:0] y);
        return {FY, FY, FY, y};
    endfunction

    task automatic add(input logic r, s, t, p, input logic [39:0] gx, input logic [35:0] gy,
                       input logic [3:0] en, input logic [1:0] st, input logic [3:0] lv,
                       input logic [15:0] sc, input logic [3:0] hm, input logic rs, go);
        vec_t v;
        v = '{r, s, t, p, gx, gy, en, st, lv, sc, hm, rs, go};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " state"},     {14'd0, state},      {14'd0, v.st});
        chk({tag, " lives"},     {12'd0, lives_left}, {12'd0, v.lv});
        chk({tag, " score"},     score,               v.sc);
        chk({tag, " hit_mask"},  {12'd0, hit_mask},   {12'd0, v.hm});
        chk({tag, " respawn"},   {15'd0, respawn},    {15'd0, v.rs});
        chk({tag, " game_over"}, {15'd0, game_over},  {15'd0, v.go});
    endtask

    initial begin
        logic [39:0] far_x;
        logic [35:0] far_y;
        vec_t        exp_v;
        far_x = {FX, FX, FX, FX};
        far_y = {FY, FY, FY, FY};
        ghost_x = far_x;
        ghost_y = far_y;

        //   rst st tk pl  gx                 gy                 en       st    lv    sc      hm       rs go
        add(1, 0, 0, 0, far_x,             far_y,             4'b0000, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 0 reset
        add(0, 0, 1, 0, gx0(10'd100),      gy0(9'd100),       4'b0001, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 1 idle, collision ignored
        add(0, 0, 0, 1, far_x,             far_y,             4'b0000, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 2 pellet in idle
        add(0, 1, 0, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd3, 16'd0, 4'b0000, 0, 0); // 3 start
        add(0, 1, 0, 1, far_x,             far_y,             4'b0000, 2'd1, 4'd3, 16'd1, 4'b0000, 0, 0); // 4 start ignored, pellet
        add(0, 0, 1, 0, gx0(10'd108),      gy0(9'd100),       4'b0001, 2'd1, 4'd3, 16'd1, 4'b0000, 0, 0); // 5 dx=8 no hit
        add(0, 0, 0, 0, gx0(10'd107),      gy0(9'd100),       4'b0001, 2'd1, 4'd3, 16'd1, 4'b0000, 0, 0); // 6 hit without tick
        add(0, 0, 1, 1, gx0(10'd107),      gy0(9'd100),       4'b0001, 2'd2, 4'd2, 16'd2, 4'b0001, 0, 0); // 7 death + pellet
        add(0, 1, 1, 1, far_x,             far_y,             4'b0000, 2'd2, 4'd2, 16'd2, 4'b0001, 0, 0); // 8 dying tick 1
        add(0, 0, 0, 0, far_x,             far_y,             4'b0000, 2'd2, 4'd2, 16'd2, 4'b0001, 0, 0); // 9 no tick
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd2, 16'd2, 4'b0001, 1, 0); // 10 respawn
        add(0, 0, 0, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd2, 16'd2, 4'b0001, 0, 0); // 11 pulse ends
        add(0, 0, 1, 0, gx0(10'd93),       gy0(9'd93),        4'b0001, 2'd2, 4'd1, 16'd2, 4'b0001, 0, 0); // 12 death at (93,93)
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd2, 4'd1, 16'd2, 4'b0001, 0, 0); // 13
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd1, 16'd2, 4'b0001, 1, 0); // 14 respawn
        add(0, 0, 1, 0, gx0(10'd93),       gy0(9'd93),        4'b0000, 2'd1, 4'd1, 16'd2, 4'b0001, 0, 0); // 15 disabled ghost
        add(0, 0, 1, 0, {10'd95, FX, 10'd100, 10'd93}, {9'd104, FY, 9'd100, 9'd93},
                                                              4'b1010, 2'd2, 4'd0, 16'd2, 4'b1010, 0, 0); // 16 ghosts 1,3
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd2, 4'd0, 16'd2, 4'b1010, 0, 0); // 17
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd3, 4'd0, 16'd2, 4'b1010, 0, 1); // 18 over
        add(0, 0, 1, 1, gx0(10'd100),      gy0(9'd100),       4'b0001, 2'd3, 4'd0, 16'd2, 4'b1010, 0, 1); // 19 hold in over
        add(0, 1, 0, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd3, 16'd0, 4'b0000, 0, 0); // 20 restart
        add(0, 0, 1, 0, {FX, FX, 10'd100, FX}, {FY, FY, 9'd100, FY},
                                                              4'b0010, 2'd2, 4'd2, 16'd0, 4'b0010, 0, 0); // 21 death ghost1
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd2, 4'd2, 16'd0, 4'b0010, 0, 0); // 22
        add(1, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 23 reset mid-dying
        add(0, 0, 1, 0, far_x,             far_y,             4'b0000, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 24
        add(1, 1, 0, 0, far_x,             far_y,             4'b0000, 2'd0, 4'd0, 16'd0, 4'b0000, 0, 0); // 25 rst wins over start
        add(0, 1, 0, 0, far_x,             far_y,             4'b0000, 2'd1, 4'd3, 16'd0, 4'b0000, 0, 0); // 26 start

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            start    = vecs[i].start;
            tick     = vecs[i].tick;
            pellet   = vecs[i].pellet;
            ghost_x  = vecs[i].gx;
            ghost_y  = vecs[i].gy;
            ghost_en = vecs[i].en;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Score saturation: 65540 pellets from zero in PLAY.
        rst = 0; start = 0; tick = 0; ghost_en = 4'b0000;
        ghost_x = far_x; ghost_y = far_y;
        pellet = 1;
        for (int n = 0; n < 65534; n++) @(posedge clk);
        #1;
        chk("score 65534", score, 16'hFFFE);
        for (int n = 0; n < 6; n++) @(posedge clk);
        #1;
        pellet = 0;
        exp_v = '{0, 0, 0, 0, far_x, far_y, 4'b0000, 2'd1, 4'd3, 16'hFFFF, 4'b0000, 0, 0};
        chk_all("saturated", exp_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4, number of ghost channels (1..8).
REQ-002 SHALL have parameter HIT_RADIUS, default 8, collision window in pixels per axis (1..63).
REQ-003 SHALL have parameter LIVES, default 3, lives loaded at game start (1..15).
REQ-004 SHALL have parameter DYING_TICKS, default 60, frame ticks spent in DYING (1..255).
REQ-005 SHALL have port clk  input  1  system clock; the only clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port tick  input  1  one-cycle frame-rate enable; all game evaluation is gated by it.
REQ-008 SHALL have port start  input  1  one-cycle start request.
REQ-009 SHALL have port pac_x  input  10  pacman x.
REQ-010 SHALL have port pac_y  input  9  pacman y.
REQ-011 SHALL have port ghost_x  input  10*NUM_GHOSTS  ghost x, ghost i at bits [10i+9:10i].
REQ-012 SHALL have port ghost_y  input  9*NUM_GHOSTS  ghost y, ghost i at bits [9i+8:9i].
REQ-013 SHALL have port ghost_en  input  NUM_GHOSTS  per-ghost enable; a disabled ghost never collides.
REQ-014 SHALL have port pellet  input  1  one-cycle pellet-eaten pulse.
REQ-015 SHALL have port state  output  2  FSM state: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER.
REQ-016 SHALL have port lives_left  output  4  remaining lives.
REQ-017 SHALL have port score  output  16  pellet count, binary.
REQ-018 SHALL have port hit_mask  output  NUM_GHOSTS  registered ghosts that caused the latest death.
REQ-019 SHALL have port respawn  output  1  one-cycle pulse on DYING->PLAY.
REQ-020 SHALL have port game_over  output  1  high iff state==OVER.

Function
REQ-021 Collision for ghost i SHALL be ghost_en[i] && |pac_x-ghost_x_i| < HIT_RADIUS && |pac_y-ghost_y_i| < HIT_RADIUS, using unsigned magnitude with one extra bit; no wrap-around.
REQ-022 IDLE: start SHALL go to PLAY next cycle, loading lives_left=LIVES, score=0, hit_mask=0.
REQ-023 PLAY: on a cycle with tick=1 and any collision, SHALL go to DYING, decrement lives_left, latch the collision vector into hit_mask, clear the dying counter.
REQ-024 Collisions on cycles with tick=0 SHALL be ignored.
REQ-025 PLAY: pellet SHALL increment score by 1, saturating at 16'hFFFF; pellet in any other state SHALL be ignored.
REQ-026 Pellet and a death collision in the same cycle SHALL both take effect.
REQ-027 DYING: dying counter SHALL count ticks; on the DYING_TICKS-th tick, go to OVER if lives_left==0, else PLAY with respawn=1 for exactly that transition cycle.
REQ-028 OVER: score, lives_left (0) and hit_mask SHALL hold; start SHALL behave as in IDLE (REQ-022).
REQ-029 start in PLAY or DYING SHALL be ignored.
REQ-030 Outputs SHALL be registered; state change visible one cycle after the qualifying input cycle.
REQ-031 Simultaneous start and rst SHALL resolve to reset.

Reset
REQ-032 On rst=1 at a clk edge: state=IDLE, lives_left=0, score=0, hit_mask=0, respawn=0, game_over=0, dying counter=0, regardless of current state, including mid-DYING.

Verification
REQ-033 start, pac=(100,100), ghost0=(107,100), ghost_en=1, tick -> DYING next cycle, lives_left=2, hit_mask=0001.
REQ-034 pac=(100,100), ghost0=(108,100) ticked -> no death (|dx|=8 not < 8); ghost0 at (93,93) -> death; ghost_en[0]=0 at same position -> no death.
REQ-035 Three deaths with DYING_TICKS=2 -> respawn pulses after deaths 1 and 2, OVER after death 3, game_over=1, lives_left=0; start -> PLAY, lives_left=3, score=0.
REQ-036 65540 pellets in PLAY -> score=16'hFFFF; pellets in IDLE/DYING -> score unchanged.
REQ-037 Ghosts 1 and 3 colliding on same tick -> hit_mask=1010, one life lost; rst asserted mid-DYING -> IDLE, all outputs zero next cycle.
